uivbuf_wr_seq: RTL and testbench

//  Write-side frame-buffer sequencer for the video DDR path. Tracks write-side

---
 rtl/uivbuf_wr_seq.sv | 98 +++++++++
 tb/tb_uivbuf_wr_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uivbuf_wr_seq.sv
// uivbuf_wr_seq: write-side frame-buffer sequencer; commits a buffer only after a fully written frame.
// Optional UIVBUF_DROP_CNT_EN adds a saturating dropped-frame counter output drop_cnt_o.
module uivbuf_wr_seq #(
  parameter int              BUF_NUM    = 3,
  parameter int              ADDR_WIDTH = 32,
  parameter logic [31:0]     BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0]     FRAME_SIZE = 32'h0020_0000,
  parameter bit              VS_POL     = 1'b1
) (
  input  logic                  ui_clk,
  input  logic                  ui_rst,
  input  logic                  vs_i,
  input  logic                  wr_done_i,
  output logic [7:0]            bufn_o,
  output logic [7:0]            wbuf_o,
  output logic [ADDR_WIDTH-1:0] base_addr_o,
  output logic                  frame_start_o,
`ifdef UIVBUF_DROP_CNT_EN
  output logic                  frame_drop_o,
  output logic [15:0]           drop_cnt_o
`else
  output logic                  frame_drop_o
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;
  localparam logic [7:0]            LAST   = 8'(BUF_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(FRAME_SIZE);
  state_t state_q, state_d;
  logic vs_act, vs_act_q, vs_rise;
  logic [7:0] wbuf_q, wbuf_d, bufn_q, bufn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic start_q, start_d, drop_q, drop_d, commit, wrap;
  assign vs_act  = vs_i ^ ~VS_POL;
  assign vs_rise = vs_act & ~vs_act_q;
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    drop_d  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE:  state_d = vs_rise ? ARMED : IDLE;
      ARMED: begin
        start_d = vs_rise;
        state_d = vs_rise ? WRITE : ARMED;
      end
      WRITE: begin
        start_d = vs_rise;
        commit  = vs_rise & wr_done_i;
        drop_d  = vs_rise & ~wr_done_i;
        state_d = (wr_done_i & ~vs_rise) ? DONE : WRITE;
      end
      DONE: begin
        start_d = vs_rise;
        commit  = vs_rise;
        state_d = vs_rise ? WRITE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Address is accumulated rather than multiplied; the wrap reloads the base.
  assign wrap   = wbuf_q == LAST;
  assign wbuf_d = commit ? (wrap ? 8'd0 : wbuf_q + 8'd1) : wbuf_q;
  assign bufn_d = commit ? wbuf_q : bufn_q;
  assign addr_d = commit ? (wrap ? BASE_A : addr_q + STEP_A) : addr_q;
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state_q  <= IDLE;
      vs_act_q <= 1'b0;
      wbuf_q   <= '0;
      bufn_q   <= '0;
      addr_q   <= BASE_A;
      start_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_act_q <= vs_act;
      wbuf_q   <= wbuf_d;
      bufn_q   <= bufn_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      drop_q   <= drop_d;
    end
  end
`ifdef UIVBUF_DROP_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) cnt_q <= '0;
    else if (drop_d && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign drop_cnt_o = cnt_q;
`endif
  assign bufn_o        = bufn_q;
  assign wbuf_o        = wbuf_q;
  assign base_addr_o   = addr_q;
  assign frame_start_o = start_q;
  assign frame_drop_o  = drop_q;
endmodule

// File: tb/tb_uivbuf_wr_seq.sv
// tb_uivbuf_wr_seq: randomized frame sequences checked against an event-level model of the sequencer.
module tb_uivbuf_wr_seq;
`ifdef UIVBUF_DROP_CNT_EN
  localparam bit POL = 1'b0;
`else
  localparam bit POL = 1'b1;
`endif
  localparam int          BN    = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] FSIZE = 32'h0020_0000;
  logic ui_clk = 1'b0, ui_rst = 1'b1, vs_i = ~POL, wr_done_i = 1'b0;
  logic [7:0] bufn_o, wbuf_o;
  logic [31:0] base_addr_o;
  logic frame_start_o, frame_drop_o;
`ifdef UIVBUF_DROP_CNT_EN
  logic [15:0] drop_cnt_o;
`endif
  int total = 0, bad = 0;
  int vs_seen = 0, commits = 0, drops = 0;
  bit done_flag = 0;
  uivbuf_wr_seq #(.BUF_NUM(BN), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .FRAME_SIZE(FSIZE), .VS_POL(POL)) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .vs_i(vs_i), .wr_done_i(wr_done_i),
    .bufn_o(bufn_o), .wbuf_o(wbuf_o), .base_addr_o(base_addr_o),
    .frame_start_o(frame_start_o),
`ifdef UIVBUF_DROP_CNT_EN
    .frame_drop_o(frame_drop_o), .drop_cnt_o(drop_cnt_o)
`else
    .frame_drop_o(frame_drop_o)
`endif
  );
  always #5 ui_clk = ~ui_clk;
  task model_clear;
    vs_seen = 0; commits = 0; drops = 0; done_flag = 0;
  endtask
  task test_reset;
    ui_rst = 1'b1;
    repeat (3) @(negedge ui_clk);
    total++;
    if (bufn_o !== 8'd0 || wbuf_o !== 8'd0 || base_addr_o !== BASE || frame_start_o !== 1'b0 || frame_drop_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: bufn=%0d wbuf=%0d addr=%h start=%b drop=%b, want 0 0 %h 0 0", bufn_o, wbuf_o, base_addr_o, frame_start_o, frame_drop_o, BASE);
    end
    ui_rst = 1'b0;
    model_clear();
    @(negedge ui_clk);
  endtask
  task do_vsync(input bit coinc, input string tag);
    bit es, ed;
    logic [7:0] ew, eb;
    logic [31:0] ea;
    @(negedge ui_clk);
    vs_i = POL;
    wr_done_i = coinc;
    es = 0; ed = 0;
    if (vs_seen == 0) vs_seen = 1;
    else if (vs_seen == 1) begin vs_seen = 2; es = 1; done_flag = 0; end
    else begin
      es = 1;
      if (done_flag || coinc) commits++;
      else begin ed = 1; drops++; end
      done_flag = 0;
    end
    ew = 8'(commits % BN);
    eb = commits == 0 ? 8'd0 : 8'((commits - 1) % BN);
    ea = BASE + 32'(ew) * FSIZE;
    @(negedge ui_clk);
    vs_i = ~POL;
    wr_done_i = 1'b0;
    total++;
    if (frame_start_o !== es || frame_drop_o !== ed) begin
      bad++;
      $display("FAIL %s pulses: start=%b drop=%b, want start=%b drop=%b", tag, frame_start_o, frame_drop_o, es, ed);
    end
    total++;
    if (wbuf_o !== ew || bufn_o !== eb || base_addr_o !== ea) begin
      bad++;
      $display("FAIL %s bufs: wbuf=%0d bufn=%0d addr=%h, want wbuf=%0d bufn=%0d addr=%h", tag, wbuf_o, bufn_o, base_addr_o, ew, eb, ea);
    end
  endtask
  task idle(input int n, input bit give_done, input string tag);
    int k;
    k = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      @(negedge ui_clk);
      total++;
      if (frame_start_o !== 1'b0 || frame_drop_o !== 1'b0) begin
        bad++;
        $display("FAIL %s idle pulses: start=%b drop=%b, want 0 0", tag, frame_start_o, frame_drop_o);
      end
      wr_done_i = give_done && i == k;
      if (wr_done_i && vs_seen == 2) done_flag = 1;
    end
  endtask
  task test_steady;
    for (int f = 0; f < 5; f++) begin
      do_vsync(1'b0, "steady");
      idle($urandom_range(2, 5), 1'b1, "steady");
    end
  endtask
  task test_drop;
    for (int f = 0; f < 6 && !(vs_seen == 2 && commits % BN == 1); f++) begin
      do_vsync(1'b0, "drop_setup");
      idle(2, 1'b1, "drop_setup");
    end
    do_vsync(1'b0, "drop_enter");
    idle(3, 1'b0, "drop");
    do_vsync(1'b0, "drop");
    idle(2, 1'b1, "drop_after");
  endtask
  task test_coincident;
    do_vsync(1'b0, "coinc_open");
    idle(3, 1'b0, "coinc");
    do_vsync(1'b1, "coinc");
    idle(2, 1'b0, "coinc_after");
  endtask
  task test_random;
    for (int f = 0; f < 25; f++) begin
      do_vsync($urandom_range(0, 3) == 0, "random");
      idle($urandom_range(1, 4), $urandom_range(0, 3) != 0, "random");
    end
  endtask
  task test_async_reset;
    for (int f = 0; f < 8 && !(vs_seen == 2 && commits % BN == 2); f++) begin
      do_vsync(1'b0, "ar_setup");
      idle(2, 1'b1, "ar_setup");
    end
    idle(1, 1'b0, "ar_mid");
    #2 ui_rst = 1'b1;
    #1;
    total++;
    if (bufn_o !== 8'd0 || wbuf_o !== 8'd0 || base_addr_o !== BASE || frame_start_o !== 1'b0 || frame_drop_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: bufn=%0d wbuf=%0d addr=%h start=%b drop=%b, want 0 0 %h 0 0", bufn_o, wbuf_o, base_addr_o, frame_start_o, frame_drop_o, BASE);
    end
    @(negedge ui_clk);
    ui_rst = 1'b0;
    model_clear();
    do_vsync(1'b0, "ar_first_vs");
    idle(2, 1'b1, "ar_after");
    do_vsync(1'b0, "ar_second_vs");
    idle(2, 1'b1, "ar_after");
  endtask
`ifdef UIVBUF_DROP_CNT_EN
  task test_drop_cnt;
    for (int d = 0; d < 3; d++) begin
      do_vsync(1'b0, "cnt");
      idle(2, 1'b0, "cnt");
    end
    do_vsync(1'b0, "cnt_last");
    total++;
    if (drop_cnt_o !== 16'(drops)) begin
      bad++;
      $display("FAIL drop_cnt: got %0d, want %0d", drop_cnt_o, drops);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_steady();
    test_drop();
    test_coincident();
    test_random();
    test_async_reset();
`ifdef UIVBUF_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
